// File: rtl/overlay_sequencer_if.sv
// overlay_sequencer_if
//   Bundles the frame-rate control inputs, the per-pixel overlay requests and
//   the sequencer outputs for overlay_sequencer.
//   master : the environment. It drives frame_tick, en_mask, hold and ov_req,
//            and it observes pix_on, sel, showing and change.
//   slave  : the sequencer. It has the opposite directions.
interface overlay_sequencer_if;
  logic       frame_tick;
  logic [3:0] en_mask;
  logic       hold;
  logic [3:0] ov_req;
  logic       pix_on;
  logic [1:0] sel;
  logic       showing;
  logic       change;

  modport master (
    output frame_tick, en_mask, hold, ov_req,
    input  pix_on, sel, showing, change
  );

  modport slave (
    input  frame_tick, en_mask, hold, ov_req,
    output pix_on, sel, showing, change
  );
endinterface

// File: rtl/overlay_sequencer.sv
// overlay_sequencer
//   Rotates an on-screen overlay through up to four text sources.
//   - Each enabled source is shown for DWELL_FRAMES frames.
//   - GAP_FRAMES blank frames follow each source.
//   - The next source is the next enabled index, in round-robin order.
//   - State, sel and the frame counter advance only on frame_tick while hold
//     is low, so sel never changes mid-frame.
//   - The pixel path runs every clk: pix_on is the registered ov_req of the
//     selected source while showing.
//
// Ports
//   clk    : pixel clock, the only clock
//   rst_n  : asynchronous active-low reset
//   bus    : overlay_sequencer_if.slave
//            inputs  frame_tick, en_mask[3:0], hold, ov_req[3:0]
//            outputs pix_on, sel[1:0], showing, change
//
// Optional feature
//   OVERLAY_BLINK_EN : when defined, pix_on is blanked in SHOW on frames where
//                      cnt >= DWELL_FRAMES-8 (or 0 for short dwells) and
//                      cnt[1] is set. This gives a pre-switch blink.
//
// States
//   IDLE | nothing shown; waiting for a tick with any source enabled
//   SHOW | source sel is displayed; cnt counts dwell frames
//   GAP  | blank interval between sources; cnt counts gap frames
module overlay_sequencer #(
  parameter int DWELL_FRAMES = 120,
  parameter int GAP_FRAMES   = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  overlay_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] sel;
  logic       showing;
  logic       change;
  logic       pix_on;
  logic       blink;
  logic       qual_tick;

  assign qual_tick = bus.frame_tick & ~bus.hold;

`ifdef OVERLAY_BLINK_EN
  localparam logic [7:0] BLINK_START = 8'((DWELL_FRAMES >= 8) ? DWELL_FRAMES - 8 : 0);
  assign blink = (state == SHOW) && (cnt >= BLINK_START) && cnt[1];
`else
  assign blink = 1'b0;
`endif

  // Returns the nearest enabled index after s, in round-robin order. The scan
  // runs from the farthest candidate to the nearest, so the nearest one is
  // assigned last and wins. s itself is kept only when no other source is
  // enabled.
  function automatic logic [1:0] next_en(input logic [1:0] s, input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    r = s;
    for (int k = 3; k >= 1; k--) begin
      idx = s + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      sel     <= 2'd3;
      showing <= 1'b0;
      change  <= 1'b0;
      pix_on  <= 1'b0;
    end else begin
      change <= 1'b0;
      pix_on <= showing & bus.ov_req[sel] & ~blink;
      if (qual_tick) begin
        unique case (state)
          IDLE: begin
            if (bus.en_mask != 4'd0) begin
              sel     <= next_en(sel, bus.en_mask);
              state   <= SHOW;
              showing <= 1'b1;
              cnt     <= 8'd0;
              change  <= 1'b1;
            end
          end
          SHOW: begin
            // A source disabled mid-dwell still passes through GAP before
            // the sequencer idles or moves on.
            if (cnt == DWELL_LAST || !bus.en_mask[sel]) begin
              state   <= GAP;
              showing <= 1'b0;
              cnt     <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          GAP: begin
            if (bus.en_mask == 4'd0) begin
              state <= IDLE;
              cnt   <= 8'd0;
            end else if (cnt == GAP_LAST) begin
              sel     <= next_en(sel, bus.en_mask);
              state   <= SHOW;
              showing <= 1'b1;
              cnt     <= 8'd0;
              change  <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: begin
            state   <= IDLE;
            showing <= 1'b0;
            cnt     <= 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.pix_on  = pix_on;
  assign bus.sel     = sel;
  assign bus.showing = showing;
  assign bus.change  = change;

endmodule

// File: tb/tb_overlay_sequencer.sv
module tb_overlay_sequencer;
  localparam int DWELL = 120;
  localparam int GAP   = 30;
  localparam int M_IDLE = 0, M_SHOW = 1, M_GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  overlay_sequencer_if bus();
  overlay_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: source rotation at frame granularity
  int m_state, m_cnt, m_sel;
  bit e_pix, e_change;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_src(input int s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(s + k) % 4]) return (s + k) % 4;
    return s;
  endfunction

  function automatic bit blink_now();
`ifdef OVERLAY_BLINK_EN
    int start;
    start = (DWELL >= 8) ? DWELL - 8 : 0;
    return (m_state == M_SHOW) && (m_cnt >= start) && (((m_cnt / 2) % 2) == 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_sel = 3; e_pix = 0; e_change = 0;
  endtask

  task automatic model_step();
    e_pix = (m_state == M_SHOW) && bus.ov_req[m_sel] && !blink_now();
    e_change = 0;
    if (bus.frame_tick && !bus.hold) begin
      if (m_state == M_IDLE) begin
        if (bus.en_mask != 0) begin
          m_sel = next_src(m_sel, bus.en_mask); m_state = M_SHOW; m_cnt = 0; e_change = 1;
        end
      end else if (m_state == M_SHOW) begin
        if (m_cnt == DWELL - 1 || !bus.en_mask[m_sel]) begin
          m_state = M_GAP; m_cnt = 0;
        end else m_cnt++;
      end else begin
        if (bus.en_mask == 0) begin
          m_state = M_IDLE; m_cnt = 0;
        end else if (m_cnt == GAP - 1) begin
          m_sel = next_src(m_sel, bus.en_mask); m_state = M_SHOW; m_cnt = 0; e_change = 1;
        end else m_cnt++;
      end
    end
  endtask

  task automatic check_outputs();
    check("pix_on",  bus.pix_on,  e_pix);
    check("change",  bus.change,  e_change);
    check("showing", bus.showing, m_state == M_SHOW);
    check("sel",     bus.sel,     m_sel);
    check("cnt",     dut.cnt,     m_cnt);
  endtask

  // Called at a negedge. Drives inputs, optionally pulses reset mid-cycle,
  // then checks at the following negedge.
  task automatic cycle(input bit tick, input bit hold_v, input logic [3:0] mask,
                       input logic [3:0] req, input bit mid_rst = 1'b0);
    bus.frame_tick = tick; bus.hold = hold_v; bus.en_mask = mask; bus.ov_req = req;
    if (mid_rst) begin
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_outputs();
      #1 rst_n = 1'b1;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic frame(input int len, input bit hold_v, input logic [3:0] mask, input logic [3:0] req);
    cycle(1'b1, hold_v, mask, req);
    repeat (len - 1) cycle(1'b0, hold_v, mask, req);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.frame_tick = 0; bus.hold = 0; bus.en_mask = 0; bus.ov_req = 0;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.frame_tick = 0; bus.hold = 0; bus.en_mask = 0; bus.ov_req = 0;
    @(negedge clk);
    do_reset();

    // First source after reset, dwell length and gap length
    cycle(1'b1, 1'b0, 4'b0101, 4'hF);
    check("r31_change", bus.change, 1);
    check("r31_sel0", bus.sel, 0);
    check("r31_show", bus.showing, 1);
    repeat (9) cycle(1'b0, 1'b0, 4'b0101, 4'hF);
    repeat (119) frame(10, 1'b0, 4'b0101, 4'hF);
    check("r31_still_show", bus.showing, 1);
    frame(10, 1'b0, 4'b0101, 4'hF);
    check("r31_gap", bus.showing, 0);
    repeat (29) frame(10, 1'b0, 4'b0101, 4'hF);
    check("r31_gap_end", bus.showing, 0);
    frame(10, 1'b0, 4'b0101, 4'hF);
    check("r31_sel2", bus.sel, 2);
    check("r31_show2", bus.showing, 1);

    // Pixel path latency and selection
    do_reset();
    cycle(1'b1, 1'b0, 4'b0010, 4'h0);
    check("r32_sel1", bus.sel, 1);
    cycle(1'b0, 1'b0, 4'b0010, 4'b0010);
    check("r32_pix1", bus.pix_on, 1);
    cycle(1'b0, 1'b0, 4'b0010, 4'b0000);
    check("r32_pix0", bus.pix_on, 0);
    cycle(1'b0, 1'b0, 4'b0010, 4'b1101);
    check("r32_pix_other", bus.pix_on, 0);

    // Disable all sources during SHOW
    cycle(1'b1, 1'b0, 4'b0000, 4'hF);
    check("r33_gap", bus.showing, 0);
    cycle(1'b0, 1'b0, 4'b0000, 4'hF);
    check("r33_pix_gap", bus.pix_on, 0);
    cycle(1'b1, 1'b0, 4'b0000, 4'hF);
    cycle(1'b0, 1'b0, 4'b0000, 4'hF);
    check("r33_idle_cnt", dut.cnt, 0);
    check("r33_sel", bus.sel, 1);
    check("r33_pix_idle", bus.pix_on, 0);

    // Hold freezes the counter and discards ticks
    do_reset();
    frame(2, 1'b0, 4'b0001, 4'h0);
    repeat (50) frame(2, 1'b0, 4'b0001, 4'h0);
    check("r34_cnt50", dut.cnt, 50);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 4'b0001, 4'h0);
      check("r34_hold_cnt", dut.cnt, 50);
      check("r34_hold_change", bus.change, 0);
    end
    cycle(1'b1, 1'b0, 4'b0001, 4'h0);
    check("r34_cnt51", dut.cnt, 51);

    // A single enabled source re-selects itself after each gap
    do_reset();
    cycle(1'b1, 1'b0, 4'b1000, 4'h8);
    check("r35_sel3", bus.sel, 3);
    check("r35_change", bus.change, 1);
    for (int r = 0; r < 2; r++) begin
      repeat (DWELL - 1) cycle(1'b1, 1'b0, 4'b1000, 4'h8);
      repeat (GAP) cycle(1'b1, 1'b0, 4'b1000, 4'h8);
      cycle(1'b1, 1'b0, 4'b1000, 4'h8);
      check("r35_resel", bus.sel, 3);
      check("r35_change_again", bus.change, 1);
    end

    // Blink window and asynchronous reset
    do_reset();
    cycle(1'b1, 1'b0, 4'b0001, 4'hF);
    repeat (114) cycle(1'b1, 1'b0, 4'b0001, 4'hF);
    cycle(1'b0, 1'b0, 4'b0001, 4'hF);
`ifdef OVERLAY_BLINK_EN
    check("r36_pix_114", bus.pix_on, 0);
`else
    check("r36_pix_114", bus.pix_on, 1);
`endif
    repeat (2) cycle(1'b1, 1'b0, 4'b0001, 4'hF);
    cycle(1'b0, 1'b0, 4'b0001, 4'hF);
    check("r36_pix_116", bus.pix_on, 1);
    cycle(1'b0, 1'b0, 4'b0001, 4'hF, 1'b1);
    check("r36_after_rst_show", bus.showing, 0);

    // Randomized traffic
    begin
      logic [3:0] mask;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 8000; i++) begin
        if ($urandom_range(0, 199) == 0) mask = 4'($urandom);
        cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, mask,
              4'($urandom), $urandom_range(0, 1999) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
